// File: rtl/decoder_pkg.sv
// Shared definitions for the 3-to-8 decoder stage and its consumers:
// line/code widths, popcount-based legality and one-hot to index encoding.
package decoder_pkg;

  localparam int LINES  = 8;
  localparam int CODE_W = 3;

  // Number of high lines in an 8-line pattern (0..8).
  function automatic logic [3:0] popcount(input logic [LINES-1:0] y);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < LINES; i++) begin
      n = n + {3'b000, y[i]};
    end
    return n;
  endfunction

  // A pattern is legal when exactly one line is high.
  function automatic logic is_onehot(input logic [LINES-1:0] y);
    return (popcount(y) == 4'd1);
  endfunction

  // Index of the lowest high line; 0 for an all-zero pattern.
  // Walking downwards lets the lowest set bit overwrite the others.
  function automatic logic [CODE_W-1:0] onehot_to_index(input logic [LINES-1:0] y);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (y[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_fifo.sv
// Small synchronous first-word fall-through FIFO holding encoded line codes.
// dout always shows the entry at the read pointer; it is only meaningful
// while empty=0. Pointers wrap modulo DEPTH (DEPTH is a power of two).
module onehot_fifo
  import decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the
  // same cycle; popping an empty FIFO is ignored.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: cleared asynchronously so a reset discards all entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array: contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/onehot_capture_encoder.sv
// Samples the decoder's one-hot lines on SAMPLE, re-encodes legal patterns
// into a 3-bit code and queues them for a valid/ready consumer. Illegal
// patterns raise sticky ERR; legal patterns dropped on a full queue raise
// sticky OVF.
// Build option: ONEHOT_PRIORITY_EN -- when defined, multi-hot patterns are
// accepted and encode their lowest high line; zero-hot is still an error.
module onehot_capture_encoder
  import decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Y0,
  input  logic              Y1,
  input  logic              Y2,
  input  logic              Y3,
  input  logic              Y4,
  input  logic              Y5,
  input  logic              Y6,
  input  logic              Y7,
  input  logic              SAMPLE,
  input  logic              CLR,
  input  logic              READY,
  output logic [CODE_W-1:0] CODE,
  output logic              VALID,
  output logic [CNT_W-1:0]  COUNT,
  output logic              FULL,
  output logic              ERR,
  output logic              OVF
);

  logic [LINES-1:0]  lines;
  logic              legal;
  logic [CODE_W-1:0] enc_code;
  logic [CODE_W-1:0] head_code;
  logic              empty;
  logic              push;
  logic              pop;
  logic              err_set;
  logic              ovf_set;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  assign lines = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

`ifdef ONEHOT_PRIORITY_EN
  assign legal = (lines != '0);
`else
  assign legal = is_onehot(lines);
`endif

  assign enc_code = onehot_to_index(lines);

  // Handshake: VALID means the queue head is on CODE; a transfer happens in
  // every cycle with VALID=1 and READY=1, and the next entry (if any) shows
  // on CODE the following cycle. READY is ignored while VALID=0.
  assign pop   = VALID && READY;
  assign push  = SAMPLE && legal && (!FULL || pop);
  assign VALID = !empty;
  assign CODE  = VALID ? head_code : '0;

  assign err_set = SAMPLE && !legal;
  assign ovf_set = SAMPLE && legal && FULL && !pop;

  onehot_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (enc_code),
    .dout  (head_code),
    .count (COUNT),
    .full  (FULL),
    .empty (empty)
  );

  // Sticky flags: a set condition beats a simultaneous CLR.
  always_comb begin
    err_d = err_q;
    ovf_d = ovf_q;
    if (CLR) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (err_set) err_d = 1'b1;
    if (ovf_set) ovf_d = 1'b1;
  end

  // Flag registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  assign ERR = err_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_onehot_capture_encoder.sv
// Bench for onehot_capture_encoder: fixed vector table for fill/overflow,
// clear and illegal-pattern cases, directed sweep and mid-queue reset, then
// randomized traffic compared against a queue-based reference model.
module tb_onehot_capture_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       y;
  logic             sample;
  logic             clr;
  logic             ready;
  logic [2:0]       code;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             err;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected queue contents plus sticky flags.
  logic [2:0] exp_q[$];
  logic       m_err;
  logic       m_ovf;

  typedef struct {
    logic [7:0] y;
    logic       s;
    logic       c;
    logic       r;
    int         cnt;
    int         code;
    logic       err;
    logic       ovf;
  } vec_t;

  vec_t tbl [16];

  onehot_capture_encoder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .Y0     (y[0]),
    .Y1     (y[1]),
    .Y2     (y[2]),
    .Y3     (y[3]),
    .Y4     (y[4]),
    .Y5     (y[5]),
    .Y6     (y[6]),
    .Y7     (y[7]),
    .SAMPLE (sample),
    .CLR    (clr),
    .READY  (ready),
    .CODE   (code),
    .VALID  (valid),
    .COUNT  (count),
    .FULL   (full),
    .ERR    (err),
    .OVF    (ovf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] yy, input logic s, input logic c, input logic r);
    y      = yy;
    sample = s;
    clr    = c;
    ready  = r;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Apply the rules for one clock to the model using the driven inputs.
  task automatic model_step();
    int   ones;
    int   idx;
    logic legal;
    logic pop;
    logic room;
    ones = $countones(y);
`ifdef ONEHOT_PRIORITY_EN
    legal = (ones >= 1);
`else
    legal = (ones == 1);
`endif
    idx = 0;
    for (int i = 7; i >= 0; i--) if (y[i]) idx = i;
    pop  = (exp_q.size() > 0) && ready;
    room = (exp_q.size() < DEPTH) || pop;
    if (pop) void'(exp_q.pop_front());
    if (sample && legal && room) exp_q.push_back(idx[2:0]);
    if (clr) begin
      m_err = 1'b0;
      m_ovf = 1'b0;
    end
    if (sample && !legal) m_err = 1'b1;
    if (sample && legal && !room) m_ovf = 1'b1;
  endtask

  task automatic check_model();
    int n;
    n = exp_q.size();
    check("count", int'(count), n);
    check("valid", int'(valid), int'(n > 0));
    check("code", int'(code), (n > 0) ? int'(exp_q[0]) : 0);
    check("full", int'(full), int'(n == DEPTH));
    check("err", int'(err), int'(m_err));
    check("ovf", int'(ovf), int'(m_ovf));
  endtask

  // One clock of model-checked traffic; called at a falling edge.
  task automatic tick_model(input logic [7:0] yy, input logic s, input logic c, input logic r);
    drive(yy, s, c, r);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model();
  endtask

  initial begin
    // Table for fill/overflow, full push+pop, CLR and illegal patterns.
    tbl[0]  = '{8'h04, 1'b1, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0};
    tbl[1]  = '{8'h10, 1'b1, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0};
    tbl[2]  = '{8'h40, 1'b1, 1'b0, 1'b0, 3, 2, 1'b0, 1'b0};
    tbl[3]  = '{8'h02, 1'b1, 1'b0, 1'b0, 4, 2, 1'b0, 1'b0};
    tbl[4]  = '{8'h80, 1'b1, 1'b0, 1'b0, 4, 2, 1'b0, 1'b1};
    tbl[5]  = '{8'h00, 1'b1, 1'b0, 1'b0, 4, 2, 1'b1, 1'b1};
    tbl[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 4, 2, 1'b0, 1'b0};
    tbl[7]  = '{8'h08, 1'b1, 1'b0, 1'b1, 4, 4, 1'b0, 1'b0};
    tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3, 6, 1'b0, 1'b0};
    tbl[9]  = '{8'h00, 1'b0, 1'b0, 1'b1, 2, 1, 1'b0, 1'b0};
    tbl[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 1, 3, 1'b0, 1'b0};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0};
    tbl[12] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
`ifdef ONEHOT_PRIORITY_EN
    tbl[14] = '{8'h22, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0};
`else
    tbl[14] = '{8'h22, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0};
`endif

    // Reset then idle.
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    do_reset();
    tick_model(8'h00, 1'b0, 1'b0, 1'b1);
    tick_model(8'h00, 1'b0, 1'b0, 1'b0);

    // Sweep: each line in turn with READY=1; code appears one cycle later.
    for (int i = 0; i < 8; i++) begin
      tick_model(8'(1 << i), 1'b1, 1'b0, 1'b1);
      check("sweep_code", int'(code), i);
    end
    tick_model(8'h00, 1'b0, 1'b0, 1'b1);
    check("sweep_err", int'(err), 0);

    // Table-driven vectors starting from an empty queue.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].y, tbl[i].s, tbl[i].c, tbl[i].r);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      check($sformatf("tbl%0d_code", i), int'(code), tbl[i].code);
      check($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].cnt > 0));
      check($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].cnt == DEPTH));
      check($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].err));
      check($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].ovf));
    end

    // Reset mid-queue: three entries, then an asynchronous reset pulse.
    do_reset();
    tick_model(8'h01, 1'b1, 1'b0, 1'b0);
    tick_model(8'h20, 1'b1, 1'b0, 1'b0);
    tick_model(8'h80, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_code", int'(code), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model();
    tick_model(8'h40, 1'b1, 1'b0, 1'b0);

    // Randomized traffic including wrap-around, errors and clears.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int         r;
      logic [7:0] yy;
      r = $urandom_range(0, 9);
      if (r < 7)       yy = 8'(1 << $urandom_range(0, 7));
      else if (r == 7) yy = 8'h00;
      else             yy = 8'($urandom_range(1, 255));
      tick_model(yy, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)));
      check("count_bound", int'(int'(count) <= DEPTH), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
